// File: rtl/spike_decoder.sv
// Spike edge decoder: inter-spike interval (ISI) with ready/valid output, plus windowed spike rate.
// Define SPIKE_DEC_SYNC_EN to insert a two-flop synchronizer on spike_in ahead of edge detection.
module spike_decoder #(
  parameter logic [23:0] WINDOW = 24'd10_000_000,
  parameter int          ISI_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic [7:0]       rate_out,
  output logic             rate_valid,
  output logic             overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [ISI_W-1:0] CNT_ONE = ISI_W'(1);
  localparam logic [ISI_W-1:0] CNT_MAX = '1;
  localparam logic [23:0]      WIN_LAST = WINDOW - 24'd1;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [ISI_W-1:0] cnt_q, cnt_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [23:0]      win_q, win_d;
  logic [7:0]       spk_q, spk_d;
  logic [7:0]       rate_q, rate_d;
  logic             rv_q, rv_d;

  logic             spike_s;
  logic             edge_det;
  logic             wrap;
  logic [7:0]       spk_inc;

`ifdef SPIKE_DEC_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if (ena) begin
      sync1_q <= spike_in;
      sync2_q <= sync1_q;
    end
  end

  assign spike_s = sync2_q;
`else
  assign spike_s = spike_in;
`endif

  assign edge_det = ena & spike_s & ~prev_q;
  assign wrap     = ena & (win_q == WIN_LAST);
  assign spk_inc  = (edge_det && (spk_q != 8'hFF)) ? spk_q + 8'd1 : spk_q;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    isi_d   = isi_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    win_d   = win_q;
    spk_d   = spk_q;
    rate_d  = rate_q;
    rv_d    = 1'b0;

    // Consumer handshake completes independently of ena.
    if (valid_q && isi_ready) valid_d = 1'b0;

    if (ena) begin
      prev_d = spike_s;
      win_d  = wrap ? 24'd0 : win_q + 24'd1;
      if (wrap) begin
        rate_d = spk_inc;
        rv_d   = 1'b1;
        spk_d  = 8'd0;
      end else begin
        spk_d = spk_inc;
      end
    end

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          cnt_d = CNT_ONE;
          // A result still waiting on the consumer wins; the new interval is dropped.
          if (valid_q && !isi_ready) begin
            ovf_d = 1'b1;
          end else begin
            isi_d   = cnt_q;
            valid_d = 1'b1;
          end
        end else if (ena && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      isi_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      win_q   <= 24'd0;
      spk_q   <= 8'd0;
      rate_q  <= 8'd0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      isi_q   <= isi_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      win_q   <= win_d;
      spk_q   <= spk_d;
      rate_q  <= rate_d;
      rv_q    <= rv_d;
    end
  end

  assign isi_out    = isi_q;
  assign isi_valid  = valid_q;
  assign rate_out   = rate_q;
  assign rate_valid = rv_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Scoreboard bench for spike_decoder: a time-based reference model queues expected ISI/rate results,
// and a negedge monitor compares them whenever the DUT presents an output.
module tb_spike_decoder;

  localparam logic [23:0] WINDOW  = 24'd600;
  localparam int          WIN     = 600;
  localparam int          ISI_W   = 16;
  localparam longint      ISI_MAX = (64'd1 << ISI_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             spike_in;
  logic             isi_ready;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;
  logic [7:0]       rate_out;
  logic             rate_valid;
  logic             overflow;

  spike_decoder #(.WINDOW(WINDOW), .ISI_W(ISI_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .isi_ready  (isi_ready),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  bit     mon_en = 1'b0;
  longint isi_q[$];
  longint rate_q[$];

  // Reference model: enabled-cycle timestamps, interval = difference of edge timestamps.
  longint m_t, m_last;
  int     m_spk;
  bit     m_armed, m_prev, m_valid, m_ovf, m_rv;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit s, input bit y);
    bit     edge_seen;
    bit     busy;
    longint iv;
    if (!r) begin
      m_t = 0; m_last = 0; m_spk = 0;
      m_armed = 0; m_prev = 0; m_valid = 0; m_ovf = 0; m_rv = 0;
      isi_q.delete();
      rate_q.delete();
      return;
    end
    m_rv      = 1'b0;
    edge_seen = e && s && !m_prev;
    if (e) m_prev = s;
    busy = m_valid && !y;
    if (m_valid && y) m_valid = 1'b0;
    if (edge_seen) begin
      if (m_armed) begin
        iv = m_t - m_last;
        if (iv > ISI_MAX) iv = ISI_MAX;
        if (busy) m_ovf = 1'b1;
        else begin
          m_valid = 1'b1;
          isi_q.push_back(iv);
        end
      end
      m_armed = 1'b1;
      m_last  = m_t;
    end
    if (e) begin
      if (edge_seen) m_spk++;
      if ((m_t % WIN) == WIN - 1) begin
        rate_q.push_back((m_spk > 255) ? 255 : m_spk);
        m_rv  = 1'b1;
        m_spk = 0;
      end
      m_t++;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit y);
    rst_n = r; ena = e; spike_in = s; isi_ready = y;
    @(posedge clk);
    #1;
    model_step(r, e, s, y);
  endtask

  task automatic do_reset();
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_isi_out", isi_out, 0);
    check("rst_isi_valid", isi_valid, 0);
    check("rst_rate_out", rate_out, 0);
    check("rst_rate_valid", rate_valid, 0);
    check("rst_overflow", overflow, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("isi_valid", isi_valid, m_valid);
      check("overflow", overflow, m_ovf);
      check("rate_valid", rate_valid, m_rv);
      if (isi_valid) begin
        check("isi_expected", isi_q.size() > 0, 1);
        if (isi_q.size() > 0) begin
          check("isi_out", isi_out, isi_q[0]);
          if (isi_ready) void'(isi_q.pop_front());
        end
      end
      if (rate_valid) begin
        check("rate_expected", rate_q.size() > 0, 1);
        if (rate_q.size() > 0) check("rate_out", rate_out, rate_q.pop_front());
      end
    end
  end

  initial begin
    int pd, pe, py;
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; isi_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    do_reset();

    // Spikes at 10, 15, 40 with a ready consumer: intervals 5 then 25.
    for (int c = 0; c < 60; c++) step(1'b1, 1'b1, (c == 10 || c == 15 || c == 40), 1'b1);

    // Stalled consumer: 10 is held, 15 is lost (overflow), then drain.
    do_reset();
    for (int c = 0; c < 45; c++) step(1'b1, 1'b1, (c == 10 || c == 20 || c == 35), 1'b0);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 1'b1);

    // Reset between two spikes discards the partial interval.
    do_reset();
    for (int c = 0; c < 30; c++) step(c != 11, 1'b1, (c == 10 || c == 15 || c == 20), 1'b1);

    // Held-high spike with a disabled stretch inside the interval.
    do_reset();
    for (int c = 0; c < 120; c++)
      step(1'b1, !(c >= 30 && c < 50), (c == 5) || (c >= 20 && c < 70) || (c == 90), 1'b1);

    // Seven spikes in one window including its last cycle, then two in the next.
    do_reset();
    for (int c = 0; c < 2 * WIN + 5; c++)
      step(1'b1, 1'b1, (c == 3 || c == 50 || c == 100 || c == 200 || c == 300 || c == 400 ||
                        c == WIN - 1 || c == WIN + 7 || c == WIN + 80), 1'b1);

    // 300 edges in one window saturate the rate at 255.
    do_reset();
    for (int c = 0; c < WIN + 5; c++) step(1'b1, 1'b1, c[0], 1'b1);

    // Interval longer than the ISI range saturates at all-ones.
    do_reset();
    for (int c = 0; c < 66010; c++) step(1'b1, 1'b1, (c == 1 || c == 66005), 1'b1);

    // Randomized segments with varying spike density, enable duty and consumer readiness.
    for (int seg = 0; seg < 60; seg++) begin
      pd = $urandom_range(5, 70);
      pe = $urandom_range(50, 100);
      py = $urandom_range(0, 100);
      if ($urandom_range(0, 99) < 8) do_reset();
      for (int c = 0; c < 200; c++)
        step(1'b1, $urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd,
             $urandom_range(0, 99) < py);
    end

    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("isi_results_delivered", isi_q.size(), 0);
    check("rate_results_delivered", rate_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 SHALL have parameter WINDOW, default 24'd10_000_000, rate-window length in clk cycles (min 2).
REQ-002 SHALL have parameter ISI_W, default 16, width of the inter-spike-interval result.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port ena, input, 1, enable; low freezes all counters and the FSM.
REQ-006 SHALL have port spike_in, input, 1, neuron spike pulse train, level-sampled.
REQ-007 SHALL have port isi_out, output, ISI_W, last measured interval in cycles.
REQ-008 SHALL have port isi_valid, output, 1, isi_out holds an unconsumed result.
REQ-009 SHALL have port isi_ready, input, 1, consumer accepts isi_out when high with isi_valid.
REQ-010 SHALL have port rate_out, output, 8, spike count of the last completed window.
REQ-011 SHALL have port rate_valid, output, 1, one-cycle pulse when rate_out updates.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an ISI result was lost.

Function
REQ-013 SHALL detect a spike edge on a clk edge where ena=1, the sampled spike_in=1, and the previous sample=0; a level held high counts once.
REQ-014 SHALL implement FSM IDLE (no spike since reset) and MEASURE (ISI counter running).
REQ-015 IDLE: first edge -> MEASURE, ISI counter := 1, no ISI result produced.
REQ-016 MEASURE: each enabled cycle without edge, counter increments, saturating at all-ones.
REQ-017 MEASURE: edge -> isi_out := counter value, isi_valid := 1 on the following cycle, counter := 1; edges at cycles 10 and 15 yield isi_out=5.
REQ-018 isi_out and isi_valid SHALL hold stable while isi_valid=1 and isi_ready=0.
REQ-019 isi_valid SHALL clear on the edge where isi_valid=1 and isi_ready=1, unless a new result is captured on the same edge, in which case isi_valid stays 1 with the new value.
REQ-020 Edge while isi_valid=1 and isi_ready=0: new value SHALL be discarded, old value kept, overflow := 1, counter still restarts at 1.
REQ-021 Window counter SHALL count enabled cycles 0..WINDOW-1 and wrap to 0.
REQ-022 Spike counter SHALL increment per edge, saturating at 255.
REQ-023 On the wrap cycle, rate_out := spike count including any edge on that cycle, rate_valid pulses 1 for one cycle, spike count := 0.
REQ-024 ena=0 SHALL hold all registers except rate_valid, which SHALL be 0; isi_ready handshake still completes while ena=0.

Reset
REQ-025 rst_n=0 at a clk edge SHALL set: FSM=IDLE, ISI counter=0, isi_out=0, isi_valid=0, window counter=0, spike count=0, rate_out=0, rate_valid=0, overflow=0, edge history=0.
REQ-026 Reset mid-measurement SHALL discard the partial interval; the first post-reset edge only re-arms (REQ-015).
REQ-027 overflow SHALL clear only by reset.

Configuration
REQ-028 Macro SPIKE_DEC_SYNC_EN SHALL control a two-flop synchronizer on spike_in.
REQ-029 With SPIKE_DEC_SYNC_EN defined: spike_in passes two flops (reset to 0) before edge detection, adding 2 cycles of latency to all responses; interval values are unchanged.
REQ-030 Without SPIKE_DEC_SYNC_EN: spike_in feeds edge detection directly; latencies per REQ-017/REQ-023.

Verification
REQ-031 WINDOW=100, isi_ready=1, single-cycle spikes at cycles 10, 15, 40 -> isi_out=5 then 25, one-cycle isi_valid each, overflow=0.
REQ-032 isi_ready=0, spikes at 10, 20, 35 -> isi_out stays 10, overflow=1; then isi_ready=1 -> isi_valid drops after one cycle.
REQ-033 WINDOW=100, 7 spikes in window incl. one on cycle 99 -> rate_out=7, rate_valid one-cycle pulse; next window starts at count 0.
REQ-034 Spikes 70000 cycles apart with ISI_W=16 -> isi_out=16'hFFFF; 300 spikes in one window -> rate_out=255.
REQ-035 Reset asserted between spikes at 10 and 15, released at 12 -> no result for the 15 spike; next spike at 20 yields isi_out=5.
REQ-036 spike_in held high 50 cycles and ena=0 for 20 cycles mid-interval -> one edge only; interval excludes the disabled cycles.
